// File: rtl/step_pulse_gen.sv
// -----------------------------------------------------------------------------
// step_pulse_gen
//
// Input conditioner in front of the 3-bit up-counter FSM. A raw push-button
// level is synchronised and then debounced. Each debounced press produces
// exactly one single-cycle step pulse on w, so one press gives one count step.
// The debounced level is also exported for status display.
//
// Optional feature: define AUTOREPEAT_EN to make a held button emit further
// w pulses REPEAT_DELAY cycles after the first pulse, then every
// REPEAT_PERIOD cycles. Without the macro no repeat logic is built and the
// REPEAT_* parameters are only range-checked.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples needed to accept
//                    a level change (>= 1)
//   REPEAT_DELAY     first pulse -> first auto-repeat pulse, in cycles (>= 2)
//   REPEAT_PERIOD    spacing of later auto-repeat pulses, in cycles (>= 2)
//
// Ports:
//   clk     in   rising-edge clock, shared with the counter FSM
//   rst     in   synchronous active-high reset
//   btn_in  in   raw asynchronous button level, 1 = pressed
//   w       out  registered single-cycle step pulse to the counter's w
//   btn_db  out  registered debounced button level
// -----------------------------------------------------------------------------
module step_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic w,
    output logic btn_db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Reject illegal parameter sets at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("step_pulse_gen: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_done;

`ifdef AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LD  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LD = RPT_W'(REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_ONE       = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_ZERO      = '0;

    // Counts down to the next repeat pulse; a value of 1 fires on this edge.
    logic [RPT_W-1:0] rpt;
`endif

    // The incremented count is what the current sample would make it; reaching
    // the target means this sample completes the stable run.
    assign cnt_inc  = cnt + CNT_ONE;
    assign cnt_done = (cnt_inc == DB_TARGET);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            w      <= 1'b0;
            btn_db <= 1'b0;
`ifdef AUTOREPEAT_EN
            rpt    <= RPT_ZERO;
`endif
        end else begin
            s1 <= btn_in;
            s2 <= s1;
            w  <= 1'b0;

            case (state)
                IDLE: begin
                    if (s2) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // Single-sample debounce: accept the press at once.
                            state  <= HELD;
                            cnt    <= '0;
                            btn_db <= 1'b1;
                            w      <= 1'b1;
`ifdef AUTOREPEAT_EN
                            rpt    <= RPT_DELAY_LD;
`endif
                        end else begin
                            state <= PRESS_WAIT;
                            cnt   <= CNT_ONE;
                        end
                    end
                end

                PRESS_WAIT: begin
                    if (s2) begin
                        if (cnt_done) begin
                            state  <= HELD;
                            cnt    <= '0;
                            btn_db <= 1'b1;
                            w      <= 1'b1;
`ifdef AUTOREPEAT_EN
                            rpt    <= RPT_DELAY_LD;
`endif
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        // Bounce during press: drop back silently.
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end

                HELD: begin
                    if (!s2) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            btn_db <= 1'b0;
                        end else begin
                            state <= REL_WAIT;
                            cnt   <= CNT_ONE;
                        end
`ifdef AUTOREPEAT_EN
                        rpt <= RPT_ZERO;
`endif
                    end
`ifdef AUTOREPEAT_EN
                    else if (rpt == RPT_ONE) begin
                        w   <= 1'b1;
                        rpt <= RPT_PERIOD_LD;
                    end else if (rpt != RPT_ZERO) begin
                        rpt <= rpt - RPT_ONE;
                    end
`endif
                end

                REL_WAIT: begin
                    if (!s2) begin
                        if (cnt_done) begin
                            // Release accepted; releases never pulse.
                            state  <= IDLE;
                            cnt    <= '0;
                            btn_db <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        // Bounce during release: still the same press, no pulse.
                        state <= HELD;
                        cnt   <= '0;
`ifdef AUTOREPEAT_EN
                        rpt   <= RPT_PERIOD_LD;
`endif
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    btn_db <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_gen
//
// Directed bench for step_pulse_gen at default parameters. Inputs change 1 ns
// after a rising edge, so the next edge is the first one to sample them;
// outputs are sampled at the same point. Step index n of a window therefore
// refers to the n-th edge after the stimulus change, and the default press
// latency puts the w pulse at step 6 (edge k+5 where edge k is step 1).
// -----------------------------------------------------------------------------
module tb_step_pulse_gen;

    logic clk;
    logic rst;
    logic btn_in;
    logic w;
    logic btn_db;

`ifdef AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    int checks;
    int failures;
    int double_w;
    logic w_prev;

    step_pulse_gen dut (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .w      (w),
        .btn_db (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One edge, then sample just after it. Tracks back-to-back w pulses.
    task automatic step();
        @(posedge clk);
        #1;
        if (w && w_prev) double_w++;
        w_prev = w;
    endtask

    // Run n edges; report pulse count, step index of first pulse (0 if none),
    // whether btn_db was ever 0 / ever 1, and btn_db after the last edge.
    task automatic collect(input int n, output int pulses, output int first,
                           output int db_lo, output int db_hi, output int db_last);
        pulses = 0; first = 0; db_lo = 0; db_hi = 0; db_last = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (w) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (btn_db) db_hi = 1; else db_lo = 1;
            db_last = int'(btn_db);
        end
    endtask

    int p, f, lo, hi, last;

    initial begin
        checks = 0; failures = 0; double_w = 0; w_prev = 1'b0;
        rst = 1'b1; btn_in = 1'b1;

        // Reset held 3 cycles with the button already pressed.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_w", int'(w), 0);
            check("rst_db", int'(btn_db), 0);
        end
        rst = 1'b0;
        collect(10, p, f, lo, hi, last);
        check("rst_press_pulses", p, 1);
        check("rst_press_first", f, 6);
        check("rst_press_db", last, 1);
        btn_in = 1'b0;
        collect(5, p, f, lo, hi, last);
        check("rst_rel_pulses", p, 0);
        check("rst_rel_db_held", lo, 0);
        step();
        check("rst_rel_db_fall", int'(btn_db), 0);
        collect(4, p, f, lo, hi, last);

        // Clean press, held 19 cycles, then released.
        btn_in = 1'b1;
        collect(5, p, f, lo, hi, last);
        check("press_early_w", p, 0);
        check("press_early_db", hi, 0);
        step();
        check("press_w", int'(w), 1);
        check("press_db", int'(btn_db), 1);
        collect(13, p, f, lo, hi, last);
        check("press_hold_pulses", p, AR ? 2 : 0);
        check("press_hold_db", lo, 0);
        btn_in = 1'b0;
        collect(5, p, f, lo, hi, last);
        check("release_pulses", p, 0);
        check("release_db_held", lo, 0);
        step();
        check("release_db_fall", int'(btn_db), 0);
        check("release_w", int'(w), 0);
        collect(4, p, f, lo, hi, last);

        // Press glitch: 3 cycles high is too short to be accepted.
        btn_in = 1'b1;
        collect(3, p, f, lo, hi, last);
        btn_in = 1'b0;
        collect(10, p, f, lo, hi, last);
        check("glitch_pulses", p, 0);
        check("glitch_db", hi, 0);

        // Release bounce: 2 low cycles while held.
        btn_in = 1'b1;
        collect(6, p, f, lo, hi, last);
        check("bounce_press_first", f, 6);
        collect(4, p, f, lo, hi, last);
        btn_in = 1'b0;
        collect(2, p, f, lo, hi, last);
        check("bounce_low_pulses", p, 0);
        check("bounce_low_db", lo, 0);
        btn_in = 1'b1;
        collect(7, p, f, lo, hi, last);
        check("bounce_back_pulses", p, AR ? 1 : 0);
        check("bounce_back_db", lo, 0);
        btn_in = 1'b0;
        collect(6, p, f, lo, hi, last);
        check("bounce_rel_pulses", p, 0);
        check("bounce_rel_db", last, 0);
        collect(4, p, f, lo, hi, last);

        // Long hold: 30 cycles.
        btn_in = 1'b1;
        collect(6, p, f, lo, hi, last);
        check("long_first", f, 6);
        collect(24, p, f, lo, hi, last);
        check("long_repeat_pulses", p, AR ? 5 : 0);
        check("long_repeat_first", f, AR ? 8 : 0);
        btn_in = 1'b0;
        collect(6, p, f, lo, hi, last);
        check("long_rel_pulses", p, 0);
        check("long_rel_db", last, 0);
        collect(4, p, f, lo, hi, last);

        // One-cycle reset while held.
        btn_in = 1'b1;
        collect(6, p, f, lo, hi, last);
        check("held_rst_press", p, 1);
        collect(3, p, f, lo, hi, last);
        rst = 1'b1;
        step();
        check("held_rst_db", int'(btn_db), 0);
        check("held_rst_w", int'(w), 0);
        rst = 1'b0;
        collect(6, p, f, lo, hi, last);
        check("held_rst_repress_pulses", p, 1);
        check("held_rst_repress_first", f, 6);
        check("held_rst_repress_db", last, 1);
        btn_in = 1'b0;
        collect(8, p, f, lo, hi, last);
        check("held_rst_rel_db", last, 0);

        check("w_back_to_back", double_w, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
